// File: rtl/spcore_seq.sv
// rtl/spcore_seq.sv - instruction sequencer stepping one spcore through read/execute/write-back
// Optional retired-instruction counter enabled by SPSEQ_PERF_EN.
module spcore_seq #(
    parameter int REG_AW = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              hold,
    output logic              done,
    output logic              illegal,
    output logic [REG_AW-1:0] x,
    output logic [REG_AW-1:0] y,
    output logic [REG_AW-1:0] z,
    output logic [DATA_W-1:0] I,
    output logic [3:0]        aluc,
    output logic [1:0]        s2,
    output logic              reg_we,
    output logic              en
`ifdef SPSEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]  retired_cnt
`endif
);

    localparam logic [3:0] OP_LOADI     = 4'd1;
    localparam logic [3:0] OP_LAST      = 4'd6;
    localparam logic [3:0] ALUC_CLEAR   = 4'd0;
    localparam logic [1:0] MUXD_FROMALU = 2'd0;
    localparam logic [1:0] MUXD_FROMI   = 2'd1;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic [3:0]  op;
    logic        is_loadi;
    logic        is_alu;
    logic        accept;

    assign op       = ir[31:28];
    assign is_loadi = (op == OP_LOADI);
    // ADD, MUL, MAD and both LOADC variants all need an execute phase
    assign is_alu   = (op > OP_LOADI) && (op <= OP_LAST);
    assign accept   = instr_valid && instr_ready;

    assign x  = REG_AW'(ir[27:24]);
    assign y  = REG_AW'(ir[23:20]);
    assign z  = REG_AW'(ir[19:16]);
    assign I  = DATA_W'(ir[15:0]);
    assign s2 = is_loadi ? MUXD_FROMI : MUXD_FROMALU;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ir      <= '0;
            illegal <= 1'b0;
            en      <= 1'b0;
        end else begin
            state <= state_nxt;
            en    <= 1'b1;
            if (accept) begin
                ir <= instr;
                if (instr[31:28] > OP_LAST)
                    illegal <= 1'b1;
            end
        end
    end

`ifdef SPSEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset)
            retired_cnt <= '0;
        else if (done)
            retired_cnt <= retired_cnt + 1'b1;
    end
`endif

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        reg_we      = 1'b0;
        aluc        = ALUC_CLEAR;
        case (state)
            IDLE: begin
                // en is low during reset, which also keeps ready low then
                instr_ready = en && !hold;
                if (instr_valid && en && !hold)
                    state_nxt = READ;
            end
            READ: begin
                if (!hold) begin
                    if (is_loadi)
                        state_nxt = WB;
                    else if (is_alu)
                        state_nxt = EXEC;
                    else begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            EXEC: begin
                aluc = op;
                if (!hold)
                    state_nxt = WB;
            end
            WB: begin
                aluc   = is_loadi ? ALUC_CLEAR : op;
                reg_we = !hold;
                done   = !hold;
                if (!hold)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spcore_seq.sv
// tb/tb_spcore_seq.sv - directed bench for spcore_seq with a small spcore register-file model
module tb_spcore_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        hold;
    logic        done;
    logic        illegal;
    logic [3:0]  x, y, z;
    logic [15:0] I;
    logic [3:0]  aluc;
    logic [1:0]  s2;
    logic        reg_we;
    logic        en;
`ifdef SPSEQ_PERF_EN
    logic [15:0] retired_cnt;
`endif

    spcore_seq dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .hold(hold), .done(done), .illegal(illegal),
        .x(x), .y(y), .z(z), .I(I), .aluc(aluc), .s2(s2), .reg_we(reg_we), .en(en)
`ifdef SPSEQ_PERF_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    // spcore stand-in: CORE_ID=100, N_CORES=200
    logic [15:0] R [16];
    int          we_cnt = 0;
    int          done_cnt = 0;

    always @(posedge clk) begin
        if (done)
            done_cnt <= done_cnt + 1;
        if (reg_we) begin
            we_cnt <= we_cnt + 1;
            if (s2 == 2'd1)
                R[x] <= I;
            else
                case (aluc)
                    4'd2:    R[x] <= R[y] + R[z];
                    4'd3:    R[x] <= R[y] * R[z];
                    4'd4:    R[x] <= R[x] + R[y] * R[z];
                    4'd5:    R[x] <= 16'd100;
                    4'd6:    R[x] <= 16'd200;
                    default: R[x] <= 16'd0;
                endcase
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_ready();
        for (int w = 0; w < 20 && instr_ready !== 1'b1; w++)
            @(negedge clk);
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                             input logic [3:0] rz, input logic [15:0] imm,
                             output int lat, output logic [3:0] aluc_d, output logic [1:0] s2_d);
        wait_ready();
        instr_valid = 1'b1;
        instr       = {op, rx, ry, rz, imm};
        @(negedge clk);
        instr_valid = 1'b0;
        lat    = 0;
        aluc_d = 4'hf;
        s2_d   = 2'd3;
        for (int n = 1; n <= 6; n++) begin
            if (done === 1'b1) begin
                lat    = n;
                aluc_d = aluc;
                s2_d   = s2;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0]  op, rx, ry, rz;
        logic [15:0] imm;
        int          lat;
        int          we;
        logic [15:0] rval;
        logic [3:0]  aluc;
        logic [1:0]  s2;
    } vec_t;

    vec_t        vecs[8];
    int          lat;
    logic [3:0]  aluc_d;
    logic [1:0]  s2_d;
    int          we0, done0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++)
            R[i] = 16'd0;
        vecs[0] = '{4'd1, 4'd0, 4'd0, 4'd0, 16'd11, 2, 1, 16'd11,  4'd0, 2'd1};
        vecs[1] = '{4'd1, 4'd1, 4'd0, 4'd0, 16'd20, 2, 1, 16'd20,  4'd0, 2'd1};
        vecs[2] = '{4'd2, 4'd2, 4'd0, 4'd1, 16'd0,  3, 1, 16'd31,  4'd2, 2'd0};
        vecs[3] = '{4'd4, 4'd2, 4'd0, 4'd1, 16'd0,  3, 1, 16'd251, 4'd4, 2'd0};
        vecs[4] = '{4'd3, 4'd2, 4'd0, 4'd1, 16'd0,  3, 1, 16'd220, 4'd3, 2'd0};
        vecs[5] = '{4'd5, 4'd3, 4'd0, 4'd0, 16'd0,  3, 1, 16'd100, 4'd5, 2'd0};
        vecs[6] = '{4'd6, 4'd3, 4'd0, 4'd0, 16'd0,  3, 1, 16'd200, 4'd6, 2'd0};
        vecs[7] = '{4'd0, 4'd3, 4'd0, 4'd0, 16'd5,  1, 0, 16'd200, 4'd0, 2'd0};

        reset = 1'b0; instr_valid = 1'b0; instr = 32'hffff_ffff; hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {31'd0, instr_ready}, 0);
        chk("rst_en",     {31'd0, en}, 0);
        chk("rst_done",   {31'd0, done}, 0);
        chk("rst_we",     {31'd0, reg_we}, 0);
        chk("rst_illegal",{31'd0, illegal}, 0);
        chk("rst_xyz",    {20'd0, x, y, z}, 0);
        chk("rst_imm",    {16'd0, I}, 0);
        chk("rst_aluc",   {28'd0, aluc}, 0);
        chk("rst_s2",     {30'd0, s2}, 0);
`ifdef SPSEQ_PERF_EN
        chk("rst_cnt",    {16'd0, retired_cnt}, 0);
`endif
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_en",    {31'd0, en}, 1);
        chk("post_rst_ready", {31'd0, instr_ready}, 1);

        for (int i = 0; i < 8; i++) begin
            we0 = we_cnt;
            run_instr(vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].rz, vecs[i].imm, lat, aluc_d, s2_d);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_aluc", i), {28'd0, aluc_d}, {28'd0, vecs[i].aluc});
            chk($sformatf("v%0d_s2", i), {30'd0, s2_d}, {30'd0, vecs[i].s2});
            @(negedge clk);
            chk($sformatf("v%0d_we_pulses", i), we_cnt - we0, vecs[i].we);
            chk($sformatf("v%0d_reg", i), {16'd0, R[vecs[i].rx]}, {16'd0, vecs[i].rval});
        end
`ifdef SPSEQ_PERF_EN
        chk("perf_cnt", {16'd0, retired_cnt}, 8);
`endif

        // hold through the write-back of LOADI R1=7
        we0 = we_cnt; done0 = done_cnt;
        wait_ready();
        instr_valid = 1'b1;
        instr = {4'd1, 4'd1, 4'd0, 4'd0, 16'd7};
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1 hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_we", k), {31'd0, reg_we}, 0);
            chk($sformatf("hold%0d_done", k), {31'd0, done}, 0);
        end
        chk("hold_x", {28'd0, x}, 1);
        chk("hold_r1_old", {16'd0, R[1]}, 20);
        hold = 1'b0;
        @(negedge clk);
        chk("hold_r1_new", {16'd0, R[1]}, 7);
        chk("hold_done_pulses", done_cnt - done0, 1);
        chk("hold_we_pulses", we_cnt - we0, 1);

        // hold in IDLE blocks acceptance
        hold = 1'b1;
        @(negedge clk);
        chk("hold_idle_ready", {31'd0, instr_ready}, 0);
        hold = 1'b0;

        // undefined opcode retires as NOP and sets sticky illegal
        we0 = we_cnt;
        run_instr(4'd9, 4'd2, 4'd0, 4'd1, 16'd0, lat, aluc_d, s2_d);
        chk("illegal_latency", lat, 1);
        chk("illegal_flag", {31'd0, illegal}, 1);
        @(negedge clk);
        chk("illegal_no_we", we_cnt - we0, 0);
        chk("illegal_sticky", {31'd0, illegal}, 1);

        // reset in the middle of an ADD
        we0 = we_cnt;
        wait_ready();
        instr_valid = 1'b1;
        instr = {4'd2, 4'd2, 4'd0, 4'd1, 16'd0};
        @(negedge clk);
        instr_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, instr_ready}, 0);
        chk("midrst_en", {31'd0, en}, 0);
        chk("midrst_illegal", {31'd0, illegal}, 0);
        chk("midrst_x", {28'd0, x}, 0);
        chk("midrst_aluc", {28'd0, aluc}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_we", we_cnt - we0, 0);
        chk("midrst_r2", {16'd0, R[2]}, 220);
        chk("midrst_idle_ready", {31'd0, instr_ready}, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
